// File: rtl/ram_4x8_ctrl_pkg.sv
// Shared definitions for the 4x8 RAM request controller and its memory model:
// controller state encoding, default geometry and RAM strobe polarity.
package ram_4x8_ctrl_pkg;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  // RAM read_write pin polarity
  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3,
    ST_INIT  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_4x8.sv
// 4-entry x 8-bit RAM: synchronous write on the rising edge while
// read_write is high, combinational read of the addressed word, and an
// asynchronous clear that zeroes every word.
module ram_4x8
  import ram_4x8_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic              read_write,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Next contents: only the addressed word changes, and only on a write strobe
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (read_write == RW_WRITE) begin
      mem_d[address] = data_in;
    end
  end

  // Storage array with asynchronous clear
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read port
  always_comb begin
    data_out = mem_q[address];
  end

endmodule

// File: rtl/ram_4x8_ctrl.sv
// Request-side controller for ram_4x8.
// Handshake rule for both channels: a transfer happens only on a rising edge
// where valid and ready are both 1; the producer holds its payload until then.
// Writes strobe the RAM for one cycle and return nothing; reads sample the
// RAM one cycle after accept and present the word on a held response channel.
// init_start (from IDLE only) sweeps zeros into every word, one per cycle.
module ram_4x8_ctrl
  import ram_4x8_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_start,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_write,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Next-state and register updates; init_start outranks a pending request
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (init_start) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        rdata_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Output decode straight from state, so clear takes effect the same cycle
  always_comb begin
    req_ready      = (state_q == ST_IDLE) && !init_start;
    busy           = (state_q != ST_IDLE);
    rsp_valid      = (state_q == ST_RESP);
    rsp_rdata      = rdata_q;
    mem_read_write = RW_READ;
    mem_address    = addr_q;
    mem_data       = '0;
    case (state_q)
      ST_WRITE: begin
        mem_read_write = RW_WRITE;
        mem_data       = wdata_q;
      end
      ST_INIT: begin
        mem_read_write = RW_WRITE;
        mem_address    = cnt_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_4x8_ctrl.sv
// Directed bench for ram_4x8_ctrl paired with the ram_4x8 memory model.
module tb_ram_4x8_ctrl;
  import ram_4x8_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       clear;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_start, busy;
  logic [1:0] mem_address;
  logic       mem_read_write;
  logic [7:0] mem_data, mem_rdata;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  ram_4x8_ctrl u_dut (
    .clock          (clock),
    .clear          (clear),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .init_start     (init_start),
    .busy           (busy),
    .mem_address    (mem_address),
    .mem_read_write (mem_read_write),
    .mem_data       (mem_data),
    .mem_rdata      (mem_rdata)
  );

  ram_4x8 u_ram (
    .clock      (clock),
    .clear      (clear),
    .address    (mem_address),
    .read_write (mem_read_write),
    .data_in    (mem_data),
    .data_out   (mem_rdata)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write: accept at edge 0, strobe in cycle 1, ready again in cycle 2
  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    chk("wr_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0; req_write = 1'b0;
    chk("wr_strobe", mem_read_write, 1);
    chk("wr_addr", mem_address, a);
    chk("wr_data", mem_data, d);
    chk("wr_busy", busy, 1);
    tick();
    chk("wr_ready_back", req_ready, 1);
    chk("wr_strobe_off", mem_read_write, 0);
  endtask

  // Read: response in cycle 2, optionally stalled for 'stall' edges
  task automatic do_read(input logic [1:0] a, input logic [7:0] d, input int stall);
    logic [7:0] e;
    exp_q.push_back(d);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    rsp_ready = (stall == 0);
    chk("rd_strobe", mem_read_write, 0);
    chk("rd_addr", mem_address, a);
    chk("rd_valid_early", rsp_valid, 0);
    tick();
    e = exp_q.pop_front();
    chk("rd_valid", rsp_valid, 1);
    chk("rd_data", rsp_rdata, e);
    chk("rd_req_ready", req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_rdata, e);
      chk("stall_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("rd_done_valid", rsp_valid, 0);
    chk("rd_done_ready", req_ready, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_strobe"}, mem_read_write, 0);
    chk({tag, "_mem_addr"}, mem_address, 0);
    chk({tag, "_mem_data"}, mem_data, 0);
  endtask

  initial begin
    clear = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b1; init_start = 1'b0;
    // Reset values while clear is held
    repeat (2) tick();
    chk_reset_outputs("rst");
    chk("rst_req_ready", req_ready, 1);
    init_start = 1'b1;
    #1;
    chk("rst_req_ready_init", req_ready, 0);
    init_start = 1'b0;
    #1;
    clear = 1'b0;
    tick();

    // Single write then read
    do_write(2'd2, 8'hA5);
    do_read(2'd2, 8'hA5, 0);

    // Fill all words, read back in reverse
    do_write(2'd0, 8'h11);
    do_write(2'd1, 8'h22);
    do_write(2'd2, 8'h33);
    do_write(2'd3, 8'h44);
    do_read(2'd3, 8'h44, 0);
    do_read(2'd2, 8'h33, 0);
    do_read(2'd1, 8'h22, 0);
    do_read(2'd0, 8'h11, 0);

    // Backpressured response
    do_read(2'd1, 8'h22, 5);

    // init_start beats a simultaneous read request
    init_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd3;
    #1;
    chk("coll_req_ready", req_ready, 0);
    tick();
    init_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sweep_busy", busy, 1);
      chk("sweep_strobe", mem_read_write, 1);
      chk("sweep_addr", mem_address, i);
      chk("sweep_data", mem_data, 0);
      chk("sweep_req_ready", req_ready, 0);
      tick();
    end
    chk("sweep_end_busy", busy, 0);
    chk("sweep_end_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("held_rd_addr", mem_address, 3);
    chk("held_rd_strobe", mem_read_write, 0);
    tick();
    chk("held_rd_valid", rsp_valid, 1);
    chk("held_rd_data", rsp_rdata, 0);
    tick();
    chk("held_rd_done", rsp_valid, 0);
    do_read(2'd0, 8'h00, 0);
    do_read(2'd1, 8'h00, 0);
    do_read(2'd2, 8'h00, 0);

    // Clear in the middle of a sweep
    do_write(2'd0, 8'hC0);
    do_write(2'd3, 8'hC3);
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick();
    tick();
    chk("mid_init_addr", mem_address, 2);
    clear = 1'b1;
    #1;
    chk_reset_outputs("clr_init");
    tick();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_clr_strobe", mem_read_write, 0);
      chk("post_clr_busy", busy, 0);
    end
    do_read(2'd0, 8'h00, 0);
    do_read(2'd1, 8'h00, 0);

    // Clear while a response is pending
    do_write(2'd0, 8'h3C);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd0;
    tick();
    req_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    chk("pend_valid", rsp_valid, 1);
    chk("pend_data", rsp_rdata, 8'h3C);
    clear = 1'b1;
    #1;
    chk_reset_outputs("clr_resp");
    chk("clr_resp_req_ready", req_ready, 1);
    tick();
    clear = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("post_clr_rsp_valid", rsp_valid, 0);

    // Back-to-back write then read with req_valid held high
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd1; req_wdata = 8'h5A;
    tick();
    req_write = 1'b0;
    chk("b2b_wr_strobe", mem_read_write, 1);
    chk("b2b_ready_c1", req_ready, 0);
    tick();
    chk("b2b_ready_c2", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_rd_addr", mem_address, 1);
    tick();
    chk("b2b_rd_valid", rsp_valid, 1);
    chk("b2b_rd_data", rsp_rdata, 8'h5A);
    tick();
    chk("b2b_done", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_4x8_ctrl.md
# ram_4x8_ctrl

Request-side controller for the 4-entry × 8-bit RAM (`ram_4x8`). It accepts read and write requests through a valid/ready handshake and drives the RAM's address, read_write and data pins with correct cycle timing. Read data returns on a buffered response channel with backpressure. A built-in sweep zeroes all four words on demand. It sits between a datapath or test sequencer and the RAM, which is the responder it serves.

## Interface
- `ADDR_W`, default 2: address width.
- `DATA_W`, default 8: data width.
- `DEPTH`, default 4: number of words, equal to 2^ADDR_W.

Ports:
- `clock`  in  1: single clock; all state changes on the rising edge.
- `clear`  in  1: reset, asynchronous and active-high.
- `req_valid`  in  1: a request is present.
- `req_ready`  out  1: the controller accepts a request this cycle.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_addr`  in  ADDR_W: word address.
- `req_wdata`  in  DATA_W: write data.
- `rsp_valid`  out  1: read data is available.
- `rsp_ready`  in  1: the consumer takes the read data.
- `rsp_rdata`  out  DATA_W: read data, held stable while `rsp_valid`=1.
- `init_start`  in  1: request a zero sweep of all words.
- `busy`  out  1: the controller is not in IDLE.
- `mem_address`  out  ADDR_W: RAM address.
- `mem_read_write`  out  1: RAM write strobe; 1 = write on the next rising edge, 0 = read.
- `mem_data`  out  DATA_W: RAM write data.
- `mem_rdata`  in  DATA_W: RAM read data, combinational from the addressed word.

## Operation
- States: IDLE, WRITE, READ, RESP, INIT.
- Registers:
  - `addr_q` (ADDR_W)
  - `wdata_q` (DATA_W)
  - `cnt` (ADDR_W)
  - `rdata_q` (DATA_W)
- Reset values:
  - state = IDLE; `addr_q` = `wdata_q` = `cnt` = `rdata_q` = 0.
  - Outputs: `rsp_valid`=0, `rsp_rdata`=0, `busy`=0, `mem_read_write`=0, `mem_address`=0, `mem_data`=0.
  - `req_ready`=1, or 0 if `init_start`=1.
- Output decode:
  - `req_ready` = (state==IDLE) & ~`init_start`.
  - `busy` = (state!=IDLE).
  - `mem_read_write` = 1 only in WRITE or INIT; never 1 in any other state.
  - `mem_address` = `cnt` in INIT, otherwise `addr_q`.
  - `mem_data` = 0 in INIT, `wdata_q` in WRITE, otherwise 0.
  - `rsp_valid` = (state==RESP); `rsp_rdata` = `rdata_q`.
- IDLE:
  - If `init_start`=1: go to INIT with `cnt`=0. `init_start` has priority over a simultaneous `req_valid`; that request is not accepted.
  - Else if `req_valid`=1: capture `req_addr` and `req_wdata`, then go to WRITE if `req_write`=1, else READ.
- WRITE: one cycle; the RAM captures `wdata_q` at `addr_q` on the edge that leaves WRITE. Next state is IDLE. Writes produce no response.
- READ: one cycle; `rdata_q` ← `mem_rdata` on the edge that leaves READ. Next state is RESP.
- RESP: hold until `rsp_ready`=1, then go to IDLE. `rsp_valid` and `rsp_rdata` must not change while waiting.
- INIT:
  - Write 0 to address `cnt`, then increment `cnt`.
  - After `cnt`==DEPTH-1 is written, go to IDLE.
  - `cnt` wraps to 0 on that exit edge; exactly DEPTH write cycles occur.
- `init_start` is ignored outside IDLE.
- `clear` asserted in any state returns immediately to the reset values. An interrupted write or sweep is abandoned, with no further strobe. A pending response is dropped.

## Timing
- The accept edge is edge 0.
  - Write: strobe high during cycle 1, RAM updated at edge 1, `req_ready` high again in cycle 2. Throughput is one write per 2 cycles.
  - Read: `mem_address` valid in cycle 1, data sampled at edge 1, `rsp_valid`=1 from cycle 2. With `rsp_ready` held at 1, `req_ready` returns in cycle 3.
- A read that immediately follows a write to the same address returns the new data; no forwarding is needed.
- Sweep: `busy`=1 for exactly DEPTH cycles plus none extra; `req_ready`=1 on the cycle after the last zero write.
- A handshake occurs only when valid and ready are both 1 at a rising edge.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE, WRITE, READ, RESP, INIT);
  - the ADDR_W/DATA_W/DEPTH defaults;
  - the read_write polarity constants (WRITE=1, READ=0).
- No sub-module is required inside the block.
- The bench pairs the controller with `ram_4x8` as the memory model, wiring its clear input to `clear`.

## Test plan
- Reset, write 0xA5 to addr 2, read addr 2 → `rsp_valid` 2 cycles after read accept, `rsp_rdata`=0xA5.
- Write 0x11, 0x22, 0x33, 0x44 to addrs 0–3, read back 3, 2, 1, 0 → 0x44, 0x33, 0x22, 0x11; addr 3 must not alias addr 2.
- Read with `rsp_ready`=0 for 5 cycles → `rsp_valid`=1 and data stable throughout, `req_ready`=0; response completes on the cycle `rsp_ready`=1.
- `init_start`=1 and `req_valid`=1 in the same cycle → sweep writes 0 to addrs 0,1,2,3 on consecutive cycles with `busy`=1 for 4 cycles, then the request is accepted; all reads return 0x00.
- `clear` pulsed mid-INIT (after 2 words) and mid-RESP → outputs at reset values in the same cycle, no further `mem_read_write`=1, `rsp_valid`=0; words already zeroed stay 0.
- Back-to-back write 0x5A then read at addr 1 with `req_valid` held high → read accepted in cycle 2, returns 0x5A.
